// File: rtl/lt24_qsys_nios2_gen2_0_oci_dct_packer.sv
// DCT trace packer: collects 2-bit trace tokens into 30-bit frames and hands them
// to the debug-capture consumer, flushing on fill, idle timeout or end of test.
module lt24_qsys_nios2_gen2_0_oci_dct_packer #(
   parameter int unsigned FLUSH_TIMEOUT = 64,
   parameter int unsigned TIMEOUT_W     = 7
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  tok_data,
   input  logic        tok_valid,
   output logic        tok_ready,
   input  logic        test_ending,
   output logic [29:0] dct_buffer,
   output logic [3:0]  dct_count,
   output logic        dct_valid,
   input  logic        dct_ready,
   output logic        test_has_ended
);

   localparam int unsigned TOK_W = 2;
   localparam int unsigned SLOTS = 15;
   localparam int unsigned BUF_W = 30;
   localparam int unsigned CNT_W = 4;

   localparam logic [CNT_W-1:0]     FULL       = CNT_W'(SLOTS);
   localparam logic [TIMEOUT_W-1:0] IDLE_MAX   = TIMEOUT_W'(FLUSH_TIMEOUT);
   localparam bit                   TIMEOUT_EN = (FLUSH_TIMEOUT != 0);

   typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

   state_t                state;
   state_t                state_next;
   logic [BUF_W-1:0]      fbuf;
   logic [BUF_W-1:0]      fbuf_next;
   logic [CNT_W-1:0]      fcnt;
   logic [CNT_W-1:0]      ins_pos;
   logic [TIMEOUT_W-1:0]  idle_cnt;
   logic                  accept;
   logic                  slot_free;
   logic                  fill_busy;
   logic                  timeout_hit;
   logic                  close_req;
   logic                  close;

   // Handshake and frame-close decisions, all from registered state
   assign tok_ready   = reset_n && (state == S_RUN) && (fcnt != FULL);
   assign accept      = tok_valid && tok_ready;
   assign slot_free   = !dct_valid || dct_ready;
   assign fill_busy   = (fcnt != '0);
   assign timeout_hit = TIMEOUT_EN && (idle_cnt == IDLE_MAX);
   assign close_req   = (fcnt == FULL) || (timeout_hit && fill_busy) ||
                        ((state == S_DRAIN) && fill_busy);
   assign close       = close_req && slot_free;
   // A token arriving on the close edge starts the next frame at slot 0
   assign ins_pos     = close ? '0 : fcnt;

   // Next fill contents: cleared on close, accepted token dropped into its slot
   always_comb begin
      fbuf_next = close ? '0 : fbuf;
      if (accept) begin
         for (int k = 0; k < int'(SLOTS); k++) begin
            if (ins_pos == CNT_W'(k)) fbuf_next[TOK_W*k +: TOK_W] = tok_data;
         end
      end
   end

   // Phase sequencing: run, drain the partial frame, then done until reset
   always_comb begin
      state_next = state;
      case (state)
         S_RUN:   if (test_ending) state_next = S_DRAIN;
         S_DRAIN: if (!fill_busy && slot_free) state_next = S_DONE;
         S_DONE:  state_next = S_DONE;
         default: state_next = S_RUN;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (!reset_n) state <= S_RUN;
      else          state <= state_next;
   end

   // Fill register; a partial frame is simply dropped by reset
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         fbuf <= '0;
         fcnt <= '0;
      end else begin
         fbuf <= fbuf_next;
         if (close)       fcnt <= accept ? CNT_W'(1) : '0;
         else if (accept) fcnt <= fcnt + CNT_W'(1);
      end
   end

   // Idle counter: counts stalled cycles of a partial frame, saturating at the timeout
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         idle_cnt <= '0;
      end else if (close || accept) begin
         idle_cnt <= '0;
      end else if (fill_busy && (idle_cnt != IDLE_MAX)) begin
         idle_cnt <= idle_cnt + TIMEOUT_W'(1);
      end
   end

   // Output slot: loads on close, holds while stalled, frees on take
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         dct_buffer <= '0;
         dct_count  <= '0;
         dct_valid  <= 1'b0;
      end else if (close) begin
         dct_buffer <= fbuf;
         dct_count  <= fcnt;
         dct_valid  <= 1'b1;
      end else if (dct_valid && dct_ready) begin
         dct_valid  <= 1'b0;
      end
   end

   // Sticky end-of-test flag, raised on the edge that enters DONE
   always_ff @(posedge clk) begin
      if (!reset_n) test_has_ended <= 1'b0;
      else          test_has_ended <= (state_next == S_DONE);
   end

endmodule

// File: tb/tb_lt24_qsys_nios2_gen2_0_oci_dct_packer.sv
// Bench for the DCT packer: directed scenarios plus random soak, checked against
// a token-queue reference model.
module tb_lt24_qsys_nios2_gen2_0_oci_dct_packer;

   localparam int unsigned TO = 8;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  tok_data;
   logic        tok_valid;
   logic        tok_ready;
   logic        test_ending;
   logic [29:0] dct_buffer;
   logic [3:0]  dct_count;
   logic        dct_valid;
   logic        dct_ready;
   logic        test_has_ended;

   int tests = 0;
   int fails = 0;

   // Reference model: pending tokens as a queue, output slot as plain values
   logic [1:0]  m_fill[$];
   int          m_phase;   // 0 running, 1 draining, 2 finished
   int          m_idle;
   logic        m_valid;
   logic [29:0] m_buf;
   logic [3:0]  m_cnt;
   logic        m_ended;

   lt24_qsys_nios2_gen2_0_oci_dct_packer #(.FLUSH_TIMEOUT(TO), .TIMEOUT_W(4)) dut (
      .clk(clk), .reset_n(reset_n), .tok_data(tok_data), .tok_valid(tok_valid),
      .tok_ready(tok_ready), .test_ending(test_ending), .dct_buffer(dct_buffer),
      .dct_count(dct_count), .dct_valid(dct_valid), .dct_ready(dct_ready),
      .test_has_ended(test_has_ended)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [29:0] pack_fill();
      logic [29:0] v = '0;
      foreach (m_fill[k]) v = v | (30'(m_fill[k]) << (2 * k));
      return v;
   endfunction

   function automatic logic model_ready(input logic rv);
      return rv && (m_phase == 0) && (m_fill.size() < 15);
   endfunction

   task automatic model_reset();
      m_fill.delete();
      m_phase = 0; m_idle = 0;
      m_valid = 1'b0; m_buf = '0; m_cnt = '0; m_ended = 1'b0;
   endtask

   // One clock of the model, evaluated on the pre-edge inputs
   task automatic model_step(input logic rv, input logic tv, input logic [1:0] td,
                             input logic te, input logic dr);
      logic acc, free, want, cls;
      int   n;
      if (!rv) begin
         model_reset();
         return;
      end
      n    = m_fill.size();
      acc  = tv && model_ready(rv);
      free = !m_valid || dr;
      want = (n == 15) || (TO != 0 && m_idle == TO && n != 0) || (m_phase == 1 && n != 0);
      cls  = want && free;
      if (cls) begin
         m_buf = pack_fill(); m_cnt = 4'(n); m_valid = 1'b1;
         m_fill.delete();
      end else if (m_valid && dr) begin
         m_valid = 1'b0;
      end
      if (cls || acc)                     m_idle = 0;
      else if (n != 0 && m_idle < int'(TO)) m_idle++;
      if (acc) m_fill.push_back(td);
      if (m_phase == 0 && te)                  m_phase = 1;
      else if (m_phase == 1 && n == 0 && free) m_phase = 2;
      if (m_phase == 2) m_ended = 1'b1;
   endtask

   // Drive one cycle, check the combinational ready, clock, then check registered outputs
   task automatic step(input logic rv, input logic tv, input logic [1:0] td,
                       input logic te, input logic dr);
      reset_n = rv; tok_valid = tv; tok_data = td; test_ending = te; dct_ready = dr;
      #1;
      chk("tok_ready", 32'(tok_ready), 32'(model_ready(rv)));
      model_step(rv, tv, td, te, dr);
      @(posedge clk);
      #1;
      chk("dct_valid", 32'(dct_valid), 32'(m_valid));
      chk("test_has_ended", 32'(test_has_ended), 32'(m_ended));
      if (m_valid || !rv) begin
         chk("dct_buffer", 32'(dct_buffer), 32'(m_buf));
         chk("dct_count", 32'(dct_count), 32'(m_cnt));
      end
   endtask

   initial begin
      logic [1:0] t3[3];
      model_reset();
      reset_n = 1'b0; tok_valid = 1'b0; tok_data = '0; test_ending = 1'b0; dct_ready = 1'b0;
      @(posedge clk); #1;

      // Reset state
      step(1'b0, 1'b1, 2'd1, 1'b0, 1'b1);
      step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
      chk("reset_count", 32'(dct_count), 32'd0);

      // Full frame of 01 tokens back-to-back
      for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 2'b01, 1'b0, 1'b1);
      chk("full_valid", 32'(dct_valid), 32'd1);
      chk("full_buffer", 32'(dct_buffer), 32'h15555555);
      chk("full_count", 32'(dct_count), 32'd15);
      step(1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
      step(1'b1, 1'b0, 2'b00, 1'b0, 1'b1);

      // Idle timeout on a 3-token partial frame, held until taken
      t3[0] = 2'b11; t3[1] = 2'b10; t3[2] = 2'b01;
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, t3[i], 1'b0, 1'b0);
      for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
      chk("timeout_valid", 32'(dct_valid), 32'd1);
      chk("timeout_buffer", 32'(dct_buffer), 32'h1B);
      chk("timeout_count", 32'(dct_count), 32'd3);
      step(1'b1, 1'b0, 2'b00, 1'b0, 1'b1);

      // Backpressure: frame held while the next fills, then back-to-back release
      for (int i = 0; i < 34; i++) step(1'b1, 1'b1, 2'($urandom), 1'b0, 1'b0);
      for (int i = 0; i < 4; i++)  step(1'b1, 1'b1, 2'($urandom), 1'b0, 1'b1);
      for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 2'b00, 1'b0, 1'b1);

      // Reset mid-frame drops the partial frame
      for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 2'($urandom), 1'b0, 1'b1);
      step(1'b0, 1'b1, 2'b10, 1'b0, 1'b1);
      for (int i = 0; i < 17; i++) step(1'b1, 1'b1, 2'($urandom), 1'b0, 1'b1);
      step(1'b1, 1'b0, 2'b00, 1'b0, 1'b1);

      // Random soak
      for (int i = 0; i < 500; i++)
         step(1'b1, ($urandom_range(0, 3) != 0), 2'($urandom), 1'b0, ($urandom_range(0, 2) != 0));

      // Flush remainder, then 5 tokens and a one-cycle end-of-test
      for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++)  step(1'b1, 1'b1, 2'($urandom), 1'b0, 1'b1);
      step(1'b1, 1'b0, 2'b00, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++)  step(1'b1, 1'b1, 2'($urandom), 1'b0, 1'b0);
      chk("drain_count", 32'(dct_count), 32'd5);
      for (int i = 0; i < 4; i++)  step(1'b1, 1'b1, 2'($urandom), 1'b1, 1'b1);
      chk("ended", 32'(test_has_ended), 32'd1);

      // End of test on the edge accepting the 15th token
      step(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
      for (int i = 0; i < 14; i++) step(1'b1, 1'b1, 2'($urandom), 1'b0, 1'b0);
      step(1'b1, 1'b1, 2'b11, 1'b1, 1'b0);
      step(1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
      chk("last_count", 32'(dct_count), 32'd15);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 2'($urandom), 1'b0, 1'b1);

      // End of test with nothing pending
      step(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
      step(1'b1, 1'b0, 2'b00, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 2'b01, 1'b0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
